life_grid_ctrl: RTL and testbench
=================================

LIFE_GRID_CTRL -- requirements
Module: life_grid_ctrl

Interface
REQ-001 SHALL have parameter ROWS, 8, grid rows (>=3).
REQ-002 SHALL have parameter COLS, 8, grid columns (>=3).
REQ-003 SHALL have parameter PERIOD, 1, clocks per generation in run mode (>=1).
REQ-004 SHALL have parameter GEN_W, 16, generation counter width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port on  input  1  enable level; low forces IDLE.
REQ-008 SHALL have port load  input  1  pulse; captures seed.
REQ-009 SHALL have port seed  input  ROWS*COLS  initial grid; cell (r,c) at bit r*COLS+c.
REQ-010 SHALL have port step  input  1  pulse; one generation while paused.
REQ-011 SHALL have port run  input  1  level; free-running evolution.
REQ-012 SHALL have port display  output  ROWS*COLS  current grid, registered.
REQ-013 SHALL have port gen_count  output  GEN_W  generations since last load, saturating.
REQ-014 SHALL have port stable  output  1  last generation equalled its predecessor.
REQ-015 SHALL have port extinct  output  1  display all zero, registered.

Function
REQ-016 SHALL implement states IDLE, PAUSE, RUN, HALT.
REQ-017 SHALL apply input priority per cycle: on low > load > run > step.
REQ-018 SHALL, in any state with on low, go to IDLE next cycle, holding display, gen_count, stable and extinct.
REQ-019 SHALL, in IDLE with on and load high, capture seed into display, clear gen_count and stable, and enter PAUSE.
REQ-020 SHALL, in PAUSE, RUN or HALT, treat load as recapture: display=seed, gen_count=0, stable=0, tick counter=0, next state PAUSE.
REQ-021 SHALL, in PAUSE with step high (run low), update display to the next generation on the following edge (latency 1).
REQ-022 SHALL, in PAUSE with run high, enter RUN with tick counter cleared.
REQ-023 SHALL, in RUN, count ticks 0..PERIOD-1 and apply one generation on the edge where the count equals PERIOD-1, then wrap to 0.
REQ-024 SHALL, in RUN with run low, enter PAUSE without applying a pending generation; tick counter cleared.
REQ-025 SHALL use Conway rule B3/S23: a live cell survives with 2 or 3 live neighbours; a dead cell births with exactly 3.
REQ-026 SHALL, on every applied generation, set stable=1 if next grid equals current grid, else 0.
REQ-027 SHALL increment gen_count by 1 per applied generation, saturating at 2^GEN_W-1.
REQ-028 SHALL, after a generation that sets stable or extinct, enter HALT; HALT freezes display and ignores step/run.
REQ-029 SHALL, if a loaded seed is all zero, set extinct but remain in PAUSE until a step/run attempt, which then enters HALT with no update.
REQ-030 SHALL ignore step while in RUN.

Reset
REQ-031 SHALL, on reset assertion, asynchronously set state=IDLE, display=0, gen_count=0, stable=0, extinct=1, tick counter=0.
REQ-032 SHALL, when reset is asserted mid-generation, discard any pending update.

Configuration
REQ-033 SHALL, with LIFE_TORUS_EN defined, wrap neighbours toroidally (row -1 is ROWS-1, column COLS wraps to 0).
REQ-034 SHALL, without LIFE_TORUS_EN, treat cells outside the grid as dead.

Structure
REQ-035 SHALL place the state enum life_state_t and the cell-index helper function in shared package life_pkg.
REQ-036 SHALL implement the next-generation rule as combinational sub-module life_next_gen (parameters ROWS, COLS; grid in, grid out).

Verification
REQ-037 SHALL verify blinker: 8x8, cells (3,2),(3,3),(3,4) loaded, three steps -> vertical, horizontal, vertical; gen_count=3; stable=0.
REQ-038 SHALL verify block still life: 2x2 at (1,1), run with PERIOD=1 -> one generation, stable=1, state HALT, gen_count=1.
REQ-039 SHALL verify extinction: single live cell, step -> display=0, extinct=1, HALT; further steps leave gen_count=1.
REQ-040 SHALL verify timing: PERIOD=4, run held -> display changes exactly every 4th clock; run dropped mid-period -> no update.
REQ-041 SHALL verify glider at grid edge: with LIFE_TORUS_EN, after 32 generations on 8x8 it returns to its seed pattern; without the macro it decays to a block and HALT.
REQ-042 SHALL verify reset and on-drop mid-RUN: reset -> all outputs at reset values next sample; on low -> IDLE with display held.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life grid controller.
// Neighbour wrapping is selected in life_next_gen by the LIFE_TORUS_EN macro.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } life_state_t;

    // Flattened bit position of cell (row, col); row-major order.
    function automatic int cell_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/life_grid_ctrl_next_gen.sv
// Combinational Conway B3/S23 next-generation rule over a flattened grid.
// Define LIFE_TORUS_EN for toroidal wrap; otherwise off-grid cells are dead.
module life_next_gen
    import life_pkg::*;
#(
    parameter int ROWS = 32'd8,
    parameter int COLS = 32'd8
) (
    input  logic [ROWS*COLS-1:0] grid,
    output logic [ROWS*COLS-1:0] next_grid
);

    function automatic logic cell_at(input logic [ROWS*COLS-1:0] g, input int idx);
        logic [ROWS*COLS-1:0] sh;
        sh = g >> idx;
        return sh[0];
    endfunction

    // Offsets are biased by +ROWS/+COLS so every coordinate stays non-negative.
    function automatic logic [3:0] live_neighbours(input logic [ROWS*COLS-1:0] g,
                                                   input int row, input int col);
        logic [3:0] n;
        int rr;
        int cc;
        n = 4'd0;
        for (int dr = 32'sd0; dr < 32'sd3; dr++) begin
            for (int dc = 32'sd0; dc < 32'sd3; dc++) begin
                rr = row + dr + ROWS - 32'sd1;
                cc = col + dc + COLS - 32'sd1;
`ifdef LIFE_TORUS_EN
                rr = rr % ROWS;
                cc = cc % COLS;
                if (dr != 32'sd1 || dc != 32'sd1) begin
                    n = n + {3'd0, cell_at(g, cell_idx(rr, cc, COLS))};
                end else begin
                    n = n;
                end
`else
                if ((dr != 32'sd1 || dc != 32'sd1) &&
                    rr >= ROWS && rr < 32'sd2 * ROWS &&
                    cc >= COLS && cc < 32'sd2 * COLS) begin
                    n = n + {3'd0, cell_at(g, cell_idx(rr - ROWS, cc - COLS, COLS))};
                end else begin
                    n = n;
                end
`endif
            end
        end
        return n;
    endfunction

    for (genvar r = 32'sd0; r < ROWS; r++) begin : g_row
        for (genvar c = 32'sd0; c < COLS; c++) begin : g_col
            localparam int IDX = cell_idx(r, c, COLS);
            logic [3:0] nbr_s;
            assign nbr_s = live_neighbours(grid, r, c);
            assign next_grid[IDX] = (nbr_s == 4'd3) || (grid[IDX] && (nbr_s == 4'd2));
        end
    end

endmodule

// File: rtl/life_grid_ctrl.sv
// Game-of-Life grid controller: seed load, single-step and timed free-run with halt detection.
// Edge behaviour follows the LIFE_TORUS_EN macro (see life_next_gen).
module life_grid_ctrl
    import life_pkg::*;
#(
    parameter int ROWS   = 32'd8,
    parameter int COLS   = 32'd8,
    parameter int PERIOD = 32'd1,
    parameter int GEN_W  = 32'd16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 on,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 step,
    input  logic                 run,
    output logic [ROWS*COLS-1:0] display,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct
);

    localparam int CELLS  = ROWS * COLS;
    localparam int TICK_W = (PERIOD > 32'sd1) ? $clog2(PERIOD) : 32'sd1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 32'sd1);
    localparam logic [GEN_W-1:0]  GEN_MAX   = {GEN_W{1'b1}};

    life_state_t       state_r;
    logic [TICK_W-1:0] tick_r;
    logic [CELLS-1:0]  next_grid_s;
    logic [GEN_W-1:0]  gen_inc_s;
    logic              next_stable_s;
    logic              next_extinct_s;
    logic              tick_last_s;
    logic              do_gen_s;

    life_next_gen #(.ROWS(ROWS), .COLS(COLS)) u_next_gen (
        .grid      (display),
        .next_grid (next_grid_s)
    );

    assign next_stable_s  = (next_grid_s == display);
    assign next_extinct_s = (next_grid_s == {CELLS{1'b0}});
    assign tick_last_s    = (tick_r == TICK_LAST);

    // A generation is applied only by an unblocked step in PAUSE or the last tick of a RUN period.
    assign do_gen_s = on && !load &&
                      (((state_r == PAUSE) && !run && step && !extinct) ||
                       ((state_r == RUN) && run && tick_last_s));

    // Saturating generation increment.
    always_comb begin
        if (gen_count != GEN_MAX) begin
            gen_inc_s = gen_count + 1'b1;
        end else begin
            gen_inc_s = gen_count;
        end
    end

    // Control FSM plus grid and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            tick_r    <= {TICK_W{1'b0}};
            display   <= {CELLS{1'b0}};
            gen_count <= {GEN_W{1'b0}};
            stable    <= 1'b0;
            extinct   <= 1'b1;
        end else if (!on) begin
            state_r <= IDLE;
        end else if (load) begin
            state_r   <= PAUSE;
            tick_r    <= {TICK_W{1'b0}};
            display   <= seed;
            gen_count <= {GEN_W{1'b0}};
            stable    <= 1'b0;
            extinct   <= (seed == {CELLS{1'b0}});
        end else begin
            case (state_r)
                IDLE: state_r <= IDLE;
                PAUSE: begin
                    if (run) begin
                        state_r <= extinct ? HALT : RUN;
                        tick_r  <= {TICK_W{1'b0}};
                    end else if (step) begin
                        state_r <= (extinct || next_stable_s || next_extinct_s) ? HALT : PAUSE;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_r <= PAUSE;
                        tick_r  <= {TICK_W{1'b0}};
                    end else if (tick_last_s) begin
                        state_r <= (next_stable_s || next_extinct_s) ? HALT : RUN;
                        tick_r  <= {TICK_W{1'b0}};
                    end else begin
                        tick_r <= tick_r + 1'b1;
                    end
                end
                HALT:    state_r <= HALT;
                default: state_r <= IDLE;
            endcase
            if (do_gen_s) begin
                display   <= next_grid_s;
                gen_count <= gen_inc_s;
                stable    <= next_stable_s;
                extinct   <= next_extinct_s;
            end
        end
    end

endmodule

// File: tb/tb_life_grid_ctrl.sv
// Directed scoreboard bench for life_grid_ctrl (8x8, PERIOD=1 and PERIOD=4 instances).
module tb_life_grid_ctrl;
    import life_pkg::*;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, on_a, on_b, load, step, run;
    logic [N-1:0]  seed;
    logic [N-1:0]  display_a, display_b;
    logic [15:0]   gen_a, gen_b;
    logic          stable_a, stable_b, extinct_a, extinct_b;

    life_grid_ctrl #(.ROWS(8), .COLS(8), .PERIOD(1), .GEN_W(16)) dut_a (
        .clk(clk), .reset(reset), .on(on_a), .load(load), .seed(seed), .step(step), .run(run),
        .display(display_a), .gen_count(gen_a), .stable(stable_a), .extinct(extinct_a)
    );

    life_grid_ctrl #(.ROWS(8), .COLS(8), .PERIOD(4), .GEN_W(16)) dut_b (
        .clk(clk), .reset(reset), .on(on_b), .load(load), .seed(seed), .step(step), .run(run),
        .display(display_b), .gen_count(gen_b), .stable(stable_b), .extinct(extinct_b)
    );

    typedef struct packed {
        logic [63:0] disp;
        logic [15:0] gen;
        logic        stable;
        logic        extinct;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] m_disp;
    logic [15:0] m_gen;
    logic        m_stable, m_extinct, m_halt;
    logic [63:0] horz, vert, blk, glider, corner;

    function automatic logic [63:0] px(input int r, input int c);
        return 64'd1 << (r * 8 + c);
    endfunction

    // Reference rule written with signed offsets on a plain 8x8 board.
    function automatic logic [63:0] life_ref(input logic [63:0] g);
        logic [63:0] nx;
        int n, rr, cc;
        nx = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_TORUS_EN
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                            if ((g & px(rr, cc)) != 64'd0) n++;
`else
                            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && (g & px(rr, cc)) != 64'd0) n++;
`endif
                        end
                    end
                end
                if (n == 3 || (n == 2 && (g & px(r, c)) != 64'd0)) nx = nx | px(r, c);
            end
        end
        return nx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        tick();
        load = 1'b0;
        m_disp = s; m_gen = 16'd0; m_stable = 1'b0; m_extinct = (s == 64'd0); m_halt = 1'b0;
    endtask

    // One step pulse on dut_a: the model's expectation is queued, then popped against the outputs.
    task automatic step_once();
        logic [63:0] nx;
        exp_t e;
        if (!m_halt) begin
            if (m_extinct) begin
                m_halt = 1'b1;
            end else begin
                nx = life_ref(m_disp);
                m_stable = (nx == m_disp);
                m_extinct = (nx == 64'd0);
                m_disp = nx;
                m_gen = m_gen + 16'd1;
                m_halt = m_stable || m_extinct;
            end
        end
        exp_q.push_back('{disp: m_disp, gen: m_gen, stable: m_stable, extinct: m_extinct});
        step = 1'b1;
        tick();
        step = 1'b0;
        e = exp_q.pop_front();
        chk("step_display", display_a, e.disp);
        chk("step_gen", {48'd0, gen_a}, {48'd0, e.gen});
        chk("step_stable", {63'd0, stable_a}, {63'd0, e.stable});
        chk("step_extinct", {63'd0, extinct_a}, {63'd0, e.extinct});
    endtask

    initial begin
        horz   = px(3, 2) | px(3, 3) | px(3, 4);
        vert   = px(2, 3) | px(3, 3) | px(4, 3);
        blk    = px(1, 1) | px(1, 2) | px(2, 1) | px(2, 2);
        glider = px(0, 1) | px(1, 2) | px(2, 0) | px(2, 1) | px(2, 2);
        corner = px(6, 6) | px(6, 7) | px(7, 6) | px(7, 7);
        reset = 1'b1; on_a = 1'b0; on_b = 1'b0; load = 1'b0; step = 1'b0; run = 1'b0; seed = 64'd0;
        tick();
        chk("rst_display", display_a, 64'd0);
        chk("rst_gen", {48'd0, gen_a}, 64'd0);
        chk("rst_stable", {63'd0, stable_a}, 64'd0);
        chk("rst_extinct", {63'd0, extinct_a}, 64'd1);
        chk("rst_state", 64'(dut_a.state_r), 64'(IDLE));
        reset = 1'b0;
        on_a = 1'b1;
        tick();

        // Blinker: three steps alternate vertical / horizontal.
        load_a(horz);
        chk("blink_load", display_a, horz);
        chk("blink_load_state", 64'(dut_a.state_r), 64'(PAUSE));
        step_once();
        chk("blink_vert1", display_a, vert);
        step_once();
        chk("blink_horz", display_a, horz);
        step_once();
        chk("blink_vert3", display_a, vert);
        chk("blink_gen", {48'd0, gen_a}, 64'd3);
        chk("blink_stable", {63'd0, stable_a}, 64'd0);

        // Block still life under run: one generation then HALT.
        load_a(blk);
        run = 1'b1;
        tick();
        tick();
        chk("block_display", display_a, blk);
        chk("block_stable", {63'd0, stable_a}, 64'd1);
        chk("block_gen", {48'd0, gen_a}, 64'd1);
        chk("block_state", 64'(dut_a.state_r), 64'(HALT));
        tick(); tick(); tick();
        chk("block_gen_hold", {48'd0, gen_a}, 64'd1);
        run = 1'b0;

        // Single cell dies; later steps are ignored in HALT.
        load_a(px(4, 4));
        step_once();
        chk("ext_state", 64'(dut_a.state_r), 64'(HALT));
        step_once();
        step_once();
        chk("ext_gen_hold", {48'd0, gen_a}, 64'd1);

        // All-zero seed stays in PAUSE until a step attempt.
        load_a(64'd0);
        chk("zero_extinct", {63'd0, extinct_a}, 64'd1);
        chk("zero_state", 64'(dut_a.state_r), 64'(PAUSE));
        step_once();
        chk("zero_state_halt", 64'(dut_a.state_r), 64'(HALT));

        // Glider started in the corner.
        load_a(glider);
`ifdef LIFE_TORUS_EN
        for (int k = 0; k < 32; k++) step_once();
        chk("glider_return", display_a, glider);
        chk("glider_gen", {48'd0, gen_a}, 64'd32);
`else
        for (int k = 0; k < 40 && !m_halt; k++) step_once();
        chk("glider_block", display_a, corner);
        chk("glider_gen", {48'd0, gen_a}, 64'd24);
        chk("glider_stable", {63'd0, stable_a}, 64'd1);
        chk("glider_state", 64'(dut_a.state_r), 64'(HALT));
`endif

        // PERIOD=4: updates exactly every 4th clock, step ignored in RUN.
        on_b = 1'b1;
        load_a(horz);
        chk("tmr_load", display_b, horz);
        run = 1'b1;
        step = 1'b1;
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("tmr_gen", {48'd0, gen_b}, 64'(i / 4));
            chk("tmr_display", display_b, ((i / 4) % 2 == 1) ? vert : horz);
        end
        tick();
        tick();
        run = 1'b0;
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tmr_drop_gen", {48'd0, gen_b}, 64'd3);
            chk("tmr_drop_display", display_b, vert);
        end
        chk("tmr_drop_state", 64'(dut_b.state_r), 64'(PAUSE));

        // on dropped mid-RUN: IDLE with outputs held.
        run = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        on_b = 1'b0;
        tick();
        chk("off_state", 64'(dut_b.state_r), 64'(IDLE));
        chk("off_display", display_b, horz);
        chk("off_gen", {48'd0, gen_b}, 64'd4);
        on_b = 1'b1;
        run = 1'b0;
        tick();
        chk("off_stay_idle", 64'(dut_b.state_r), 64'(IDLE));

        // Reset asserted one edge before a pending generation.
        load_a(horz);
        run = 1'b1;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_display", display_b, 64'd0);
        chk("mid_rst_gen", {48'd0, gen_b}, 64'd0);
        chk("mid_rst_stable", {63'd0, stable_b}, 64'd0);
        chk("mid_rst_extinct", {63'd0, extinct_b}, 64'd1);
        chk("mid_rst_state", 64'(dut_b.state_r), 64'(IDLE));
        tick();
        reset = 1'b0;
        run = 1'b0;
        tick();
        chk("post_rst_display", display_b, 64'd0);
        chk("post_rst_state", 64'(dut_b.state_r), 64'(IDLE));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
